nsagp_bus_master: RTL



---
 rtl/nsagp_bus_master_if.sv | 25 ++
 rtl/nsagp_bus_master.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/nsagp_bus_master_if.sv
// Request/response handshake plus the NSAGP address/strobe pins.
// The bidirectional DATA pin is a separate inout port on the master itself.
interface nsagp_bus_master_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_WR;
  logic [1:0] REQ_ADDR;
  logic [7:0] REQ_WDATA;
  logic       RSP_VALID;
  logic [7:0] RSP_RDATA;
  logic       BUSY;
  logic [1:0] ADDR;
  logic       nWR;
  logic       nRD;

  modport master (
    input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, BUSY, ADDR, nWR, nRD
  );

  modport slave (
    output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, BUSY, ADDR, nWR, nRD
  );
endinterface

// File: rtl/nsagp_bus_master.sv
// NSAGP host-side bus initiator: turns single-word requests into
// setup / strobe / hold cycles on ADDR, DATA, nWR and nRD, then returns a
// one-cycle response pulse. All bus pins come straight from flops.
module nsagp_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic               CLK,
  input  logic               RST,
  nsagp_bus_master_if.master bus,
  inout  wire  [7:0]         DATA
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // A zero phase length would wrap the down-counter, so it is treated as 1.
  localparam int SETUP_EFF  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
  localparam int STROBE_EFF = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
  localparam int HOLD_EFF   = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_EFF);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_EFF);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_EFF);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       wr_q,    wr_d;
  logic [1:0] addr_q,  addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       oe_q,    oe_d;
  logic       nwr_q,   nwr_d;
  logic       nrd_q,   nrd_d;

  logic       ready;
  logic       accept;
  logic       last_cnt;
  logic       on_bus_d;

  assign ready    = (state_q == S_IDLE) && !RST;
  assign accept   = bus.REQ_VALID && ready;
  assign last_cnt = (cnt_q <= 4'd1);

  // Next-state, phase counter, request latch, read capture and next pin values.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          wr_d    = bus.REQ_WR;
          addr_d  = bus.REQ_ADDR;
          wdata_d = bus.REQ_WDATA;
        end
      end
      S_SETUP: begin
        if (last_cnt) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (last_cnt) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          // Read data is taken on the edge that raises nRD.
          if (!wr_q) rdata_d = DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (last_cnt) begin
          state_d = S_DONE;
          cnt_d   = 4'd1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Pins are derived from the next state so the flops present them
    // exactly during the matching state, without decode glitches.
    on_bus_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    oe_d     = on_bus_d && wr_d;
    nwr_d    = !((state_d == S_STROBE) && wr_d);
    nrd_d    = !((state_d == S_STROBE) && !wr_d);
  end

  // State, counter, latched request and registered bus pins.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 2'b00;
      wdata_q <= 8'h00;
      rdata_q <= 8'hFF;
      oe_q    <= 1'b0;
      nwr_q   <= 1'b1;
      nrd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      nwr_q   <= nwr_d;
      nrd_q   <= nrd_d;
    end
  end

  assign DATA          = oe_q ? wdata_q : 8'hzz;
  assign bus.ADDR      = addr_q;
  assign bus.nWR       = nwr_q;
  assign bus.nRD       = nrd_q;
  assign bus.REQ_READY = ready;
  assign bus.RSP_VALID = (state_q == S_DONE);
  assign bus.RSP_RDATA = rdata_q;
  assign bus.BUSY      = (state_q != S_IDLE);

endmodule
